// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 host transmitter and the keyboard
// receiver.
//   - ps2_state_e    : host transmit FSM states
//   - odd_parity     : parity bit that makes a byte plus parity odd
//   - inhibit_cycles : clk cycles in the clock-inhibit window
//   - timeout_cycles : clk cycles in the release-to-ack window
//   - cnt_width      : counter width that can hold a value 0..n
`timescale 1ns/1ps
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_RELEASE,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_state_e;

  localparam int DEF_CLK_HZ     = 25000000;
  localparam int DEF_INHIBIT_US = 120;
  localparam int DEF_TIMEOUT_MS = 15;
  localparam int DEF_FILTER_LEN = 4;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // The multiply is done in 64 bits because CLK_HZ * us overflows 32 bits.
  function automatic int unsigned inhibit_cycles(input int unsigned clk_hz,
                                                 input int unsigned us);
    return int'((longint'(clk_hz) * longint'(us)) / 64'd1000000);
  endfunction

  function automatic int unsigned timeout_cycles(input int unsigned clk_hz,
                                                 input int unsigned ms);
    return int'((longint'(clk_hz) * longint'(ms)) / 64'd1000);
  endfunction

  function automatic int cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: conditions one asynchronous open-drain PS/2 pad input.
//   clk, reset : system clock, synchronous active-high reset
//   line_i     : raw pad input
//   level_o    : synchronised level; glitch-filtered when FILTER_LEN > 1
//   fall_o     : one-cycle pulse when level_o goes 1 -> 0
// With FILTER_LEN > 1 a new level is accepted only after FILTER_LEN
// consecutive synchronised samples disagree with the current level.
`timescale 1ns/1ps
module ps2_line_sync
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  // Reset to 1: an idle, released PS/2 line reads high.
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], line_i};
    end
  end

  generate
    if (FILTER_LEN > 1) begin : g_filt
      localparam int CW = $clog2(FILTER_LEN);
      logic [CW-1:0] cnt_q;
      logic          level_q;
      logic          fall_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q   <= '0;
          level_q <= 1'b1;
          fall_q  <= 1'b0;
        end else begin
          fall_q <= 1'b0;
          if (sync_q[1] == level_q) begin
            cnt_q <= '0;
          end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
            // This is the FILTER_LEN-th disagreeing sample in a row.
            cnt_q   <= '0;
            level_q <= sync_q[1];
            fall_q  <= level_q & ~sync_q[1];
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
      end

      assign level_o = level_q;
      assign fall_o  = fall_q;
    end else begin : g_raw
      logic prev_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          prev_q <= 1'b1;
        end else begin
          prev_q <= sync_q[1];
        end
      end

      assign level_o = sync_q[1];
      assign fall_o  = prev_q & ~sync_q[1];
    end
  endgenerate

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte from the host to a PS/2 device over
// the open-drain ps2Clk/ps2Data lines (inhibit, start, 8 data LSB first,
// odd parity, stop, device ack).
//   clk, reset   : system clock, synchronous active-high reset
//   tx_data      : byte to send
//   tx_valid     : request, accepted when tx_valid & tx_ready
//   tx_ready     : high only while idle
//   busy         : high from the cycle after accept until done/err
//   ps2_clk_i    : raw ps2Clk pad input
//   ps2_data_i   : raw ps2Data pad input
//   ps2_clk_oe   : 1 pulls ps2Clk low, 0 releases it
//   ps2_data_oe  : 1 pulls ps2Data low, 0 releases it
//   done         : one-cycle pulse, device acknowledged the byte
//   err          : one-cycle pulse, timeout or missing ack
`timescale 1ns/1ps
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = DEF_CLK_HZ,
  parameter int INHIBIT_US = DEF_INHIBIT_US,
  parameter int TIMEOUT_MS = DEF_TIMEOUT_MS,
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       err
);

  localparam int unsigned INH_CYC = inhibit_cycles(CLK_HZ, INHIBIT_US);
  localparam int unsigned TMO_CYC = timeout_cycles(CLK_HZ, TIMEOUT_MS);
  localparam int          INH_W   = cnt_width(INH_CYC);
  localparam int          TMO_W   = cnt_width(TMO_CYC);

  logic clk_lvl;
  logic clk_fall;
  logic data_lvl;
  logic data_fall_unused;

  ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_clk_sync (
    .clk     (clk),
    .reset   (reset),
    .line_i  (ps2_clk_i),
    .level_o (clk_lvl),
    .fall_o  (clk_fall)
  );

  // Data only needs synchronising; it is sampled at filtered clock edges.
  ps2_line_sync #(.FILTER_LEN(1)) u_data_sync (
    .clk     (clk),
    .reset   (reset),
    .line_i  (ps2_data_i),
    .level_o (data_lvl),
    .fall_o  (data_fall_unused)
  );

  ps2_state_e        state_q, state_d;
  logic [9:0]        shift_q, shift_d;
  logic [3:0]        bitcnt_q, bitcnt_d;
  logic [INH_W-1:0]  inh_q, inh_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              drive_q, drive_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      bitcnt_q <= '0;
      inh_q    <= '0;
      tmo_q    <= '0;
      drive_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      inh_q    <= inh_d;
      tmo_q    <= tmo_d;
      drive_q  <= drive_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    inh_d    = inh_q;
    tmo_d    = tmo_q;
    drive_d  = drive_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          shift_d = {1'b1, odd_parity(tx_data), tx_data};
          inh_d   = INH_W'(INH_CYC - 1);
          state_d = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (inh_q == '0) begin
          state_d = ST_START;
        end else begin
          inh_d = inh_q - INH_W'(1);
        end
      end

      ST_START: begin
        state_d = ST_RELEASE;
      end

      ST_RELEASE: begin
        // The release cycle is the first of the TMO_CYC counted cycles.
        tmo_d    = TMO_W'(TMO_CYC - 1);
        bitcnt_d = '0;
        drive_d  = 1'b1;
        state_d  = ST_SHIFT;
      end

      ST_SHIFT, ST_ACK, ST_WAIT_IDLE: begin
        tmo_d = tmo_q - TMO_W'(1);
        if (tmo_q == TMO_W'(1)) begin
          // Checked first so a timeout beats an ack in the same cycle.
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (state_q == ST_SHIFT) begin
          if (clk_fall) begin
            drive_d  = ~shift_q[bitcnt_q];
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd9) begin
              state_d = ST_ACK;
            end
          end
        end else if (state_q == ST_ACK) begin
          if (clk_fall) begin
            if (!data_lvl) begin
              state_d = ST_WAIT_IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end else begin
          if (clk_lvl && data_lvl) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign tx_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign ps2_clk_oe  = (state_q == ST_INHIBIT) || (state_q == ST_START);
  assign ps2_data_oe = (state_q == ST_START) || (state_q == ST_RELEASE) ||
                       ((state_q == ST_SHIFT) && drive_q);
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: bench for ps2_host_tx with a behavioural PS/2 device.
// Timing parameters are scaled down (CLK_HZ = 1 MHz) so the inhibit window is
// 120 cycles and the timeout 15000 cycles; the device clock half-period of
// 40 cycles corresponds to 12.5 kHz at that rate.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int CLK_HZ     = 1000000;
  localparam int INHIBIT_US = 120;
  localparam int TIMEOUT_MS = 15;
  localparam int FILTER_LEN = 4;
  localparam int INH        = 120;     // 120 us at 1 MHz
  localparam int TMO        = 15000;   // 15 ms at 1 MHz
  localparam int H          = 40;      // device half period in cycles

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, err;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_line, ps2_data_line;

  // Wired-AND of the open-drain drivers with the pull-up.
  assign ps2_clk_line  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_line = dev_data & ~ps2_data_oe;

  always #20 clk = ~clk;

  ps2_host_tx #(
    .CLK_HZ(CLK_HZ), .INHIBIT_US(INHIBIT_US),
    .TIMEOUT_MS(TIMEOUT_MS), .FILTER_LEN(FILTER_LEN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .ps2_clk_i   (ps2_clk_line),
    .ps2_data_i  (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .done        (done),
    .err         (err)
  );

  int       n_tests = 0;
  int       n_fail = 0;
  int       cyc = 0;
  int       clk_oe_cnt = 0;
  int       expect_kind = 0;   // 0 done, 1 nack err, 2 timeout err, 3 aborted
  int       dev_evt_cyc = 0;
  int       dev_edges = 0;
  bit       m_act = 1'b0;
  bit [9:0] dev_bits;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (ps2_clk_oe) clk_oe_cnt <= clk_oe_cnt + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bits as the device must see them on the wire: data LSB first, odd parity, stop.
  function automatic logic [9:0] frame(input logic [7:0] b);
    return {1'b1, ($countones(b) % 2 == 0), b};
  endfunction

  // Cycle-level model: after an accepted request the host inhibits for INH
  // cycles, asserts start for one, releases for one, then stays busy until
  // a single done or err pulse coinciding with the return to idle.
  initial begin : compare
    int k;
    bit idle_now;
    logic [1:0] kind_exp;
    k = 0;
    repeat (2) @(negedge clk);
    forever begin
      @(negedge clk);
      idle_now = !m_act;
      if (!m_act) begin
        check("idle", {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, err}, 6'b100000);
      end else begin
        k++;
        if (k <= INH) begin
          check("inhibit", {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, err}, 6'b011000);
        end else if (k == INH + 1) begin
          check("start", {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, err}, 6'b011100);
        end else if (k == INH + 2) begin
          check("release", {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, err}, 6'b010100);
        end else if (done || err) begin
          kind_exp = (expect_kind == 0) ? 2'b10 : (expect_kind == 3) ? 2'b00 : 2'b01;
          check("end_lines", {tx_ready, busy, ps2_clk_oe, ps2_data_oe}, 4'b1000);
          check("end_kind", {done, err}, kind_exp);
          if (expect_kind == 2)
            check("timeout_cycles", k - (INH + 2), TMO);
          else if (expect_kind != 3)
            check("end_latency", longint'((cyc - dev_evt_cyc) inside {[1:15]}), 1);
          m_act = 1'b0;
          idle_now = 1'b1;
        end else begin
          check("busy", {tx_ready, busy, ps2_clk_oe}, 3'b010);
          if (k - (INH + 2) > TMO + 50) begin
            check("transfer_overrun", k, INH + 2 + TMO);
            m_act = 1'b0;
          end
        end
      end
      if (reset) begin
        m_act = 1'b0;
      end else if (idle_now && tx_valid) begin
        m_act = 1'b1;
        k = 0;
      end
    end
  end

  // Device side: wait for request-to-send, clock 10 bits in, then ack (or not).
  task automatic dev_run(input bit do_ack, input bit glitch);
    int w;
    w = 0;
    dev_edges = 0;
    dev_bits = '0;
    while (!(ps2_clk_line && !ps2_data_line) && w < 2000) begin
      @(posedge clk);
      w++;
    end
    check("dev_request_seen", longint'(w < 2000), 1);
    if (w >= 2000) return;
    repeat (H) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      #1 dev_clk = 1'b0;
      dev_edges++;
      repeat (H) @(posedge clk);
      dev_bits[i] = ps2_data_line;
      #1 dev_clk = 1'b1;
      if (glitch) begin
        repeat (H / 2) @(posedge clk);
        #7 dev_clk = 1'b0;
        #50 dev_clk = 1'b1;
        repeat (H / 2) @(posedge clk);
      end else begin
        repeat (H) @(posedge clk);
      end
    end
    #1 if (do_ack) dev_data = 1'b0;
    repeat (10) @(posedge clk);
    #1 dev_clk = 1'b0;
    dev_evt_cyc = cyc;
    if (glitch) tx_valid = 1'b0;
    repeat (H) @(posedge clk);
    #1 dev_clk = 1'b1;
    repeat (H / 2) @(posedge clk);
    #1 dev_data = 1'b1;
    if (do_ack) dev_evt_cyc = cyc;
  endtask

  task automatic wait_idle(input int bound);
    int w;
    w = 0;
    while (m_act && w < bound) begin
      @(posedge clk);
      w++;
    end
    check("transfer_ended", m_act, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int kind, input bit glitch);
    expect_kind = kind;
    @(posedge clk);
    #1 tx_data = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 if (!glitch) tx_valid = 1'b0;
    if (kind != 2) dev_run(kind == 0, glitch);
    wait_idle(TMO + INH + 500);
    if (kind != 2) check("frame", dev_bits, frame(b));
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stimulus
    int oe0;
    int w;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, err}, 6'b100000);

    // Set-LEDs command.
    oe0 = clk_oe_cnt;
    send(8'hED, 0, 1'b0);
    check("frame_ED_literal", dev_bits, 10'h3ED);
    check("clk_low_cycles", clk_oe_cnt - oe0, INH + 1);
    check("ready_after_ED", tx_ready, 1);

    // Parity corners.
    send(8'h00, 0, 1'b0);
    check("frame_00_literal", dev_bits, 10'h300);
    send(8'hFF, 0, 1'b0);
    check("frame_FF_literal", dev_bits, 10'h3FF);
    send(8'h01, 0, 1'b0);
    check("frame_01_literal", dev_bits, 10'h201);

    // Silent device: timeout.
    send(8'hFF, 2, 1'b0);
    check("lines_after_timeout", {ps2_clk_oe, ps2_data_oe}, 2'b00);

    // Device does not ack.
    send(8'h55, 1, 1'b0);
    check("lines_after_nack", {ps2_clk_oe, ps2_data_oe}, 2'b00);

    // Reset in the middle of the shift phase.
    expect_kind = 3;
    @(posedge clk);
    #1 tx_data = 8'hA5;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    fork
      dev_run(1'b1, 1'b0);
      begin
        w = 0;
        while (dev_edges < 5 && w < 20000) begin
          @(posedge clk);
          w++;
        end
        check("reached_bit4", longint'(dev_edges >= 5), 1);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_mid_shift", {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, err}, 6'b100000);
        reset = 1'b0;
      end
    join
    repeat (5) @(posedge clk);
    send(8'hF4, 0, 1'b0);
    check("frame_F4_literal", dev_bits, 10'h2F4);

    // Glitches on the clock while tx_valid stays high.
    send(8'h3C, 0, 1'b1);
    check("frame_3C_literal", dev_bits, 10'h33C);
    check("ready_after_glitch", tx_ready, 1);

    repeat (10) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard on the shared ps2Clk/ps2Data open-drain lines. It is the opposite direction of the existing PS/2 keyboard receiver. It runs on the 25 MHz system clock `clk`, alongside the `ps2` and `keyboard` blocks. Top-level tristates are `assign ps2Clk = clk_oe ? 1'b0 : 1'bz` (same for data).

Parameters:
CLK_HZ, 25000000, frequency of clk in Hz
INHIBIT_US, 120, duration the clock line is held low before the start bit is released (min 100 per PS/2)
TIMEOUT_MS, 15, limit from clock release to ack; on expiry the transfer aborts
FILTER_LEN, 4, number of consecutive equal synchronised samples needed to accept a new ps2_clk level (glitch filter)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tx_data  in  8  byte to send, LSB first
tx_valid  in  1  request; accepted on a cycle where tx_valid & tx_ready
tx_ready  out  1  high only in IDLE
busy  out  1  high from accept to done/err; the receiver ignores frames while high
ps2_clk_i  in  1  raw ps2Clk pad input (async)
ps2_data_i  in  1  raw ps2Data pad input (async)
ps2_clk_oe  out  1  1 = drive ps2Clk low, 0 = release
ps2_data_oe  out  1  1 = drive ps2Data low, 0 = release
done  out  1  one-cycle pulse: device acked (data low at 11th falling edge)
err  out  1  one-cycle pulse: timeout or missing ack

Behaviour:
- Inputs: 2-FF synchroniser, then FILTER_LEN glitch filter on clk. Falling edge = filtered clk 1->0. Data is sampled from the synchronised value at the filtered falling edge.
- Reset (sync): state IDLE; tx_ready=1; busy=0; both oe=0; done=err=0; counters cleared. Reset mid-transfer releases both lines on the next clk edge with no partial pulse.
- Frame is latched on accept: shift = {stop=1, parity=~^tx_data, tx_data} (10 bits; odd parity).
- IDLE: on accept go to INHIBIT next cycle. tx_ready=0 and busy=1 from the cycle after accept.
- INHIBIT: clk_oe=1, data_oe=0 for INHIBIT_US*CLK_HZ/1e6 cycles (3000 at defaults). Then data_oe=1 (start bit) for 1 cycle with clk still low, then go to RELEASE.
- RELEASE: clk_oe=0, data_oe=1. Load the timeout counter with TIMEOUT_MS*CLK_HZ/1000 (375000 at defaults). Go to SHIFT with bitcnt=0.
- SHIFT: on each falling edge, data_oe <= ~shift[bitcnt] and bitcnt++. After the 10th edge (stop bit, data released), go to ACK.
- ACK: on the next (11th) falling edge, sample data. If 0, go to WAIT_IDLE; if 1, pulse err and go to IDLE (lines already released).
- WAIT_IDLE: wait for filtered clk=1 and data=1. Then pulse done and go to IDLE.
- Timeout counter decrements every cycle in RELEASE/SHIFT/ACK/WAIT_IDLE. On reaching 0: both oe=0, err pulse, go to IDLE. If timeout and ack happen in the same cycle, timeout wins.
- tx_valid while busy is ignored (not queued). done and err never assert together.
- The block never drives a line high (open-drain only).

Decomposition:
- Package ps2_pkg: state encoding (IDLE, INHIBIT, START, RELEASE, SHIFT, ACK, WAIT_IDLE), odd-parity function, cycle-count constants derived from CLK_HZ/INHIBIT_US/TIMEOUT_MS, and a clog2-based counter width. These are shared with the receiver.
- One sub-module, ps2_line_sync: 2-FF sync plus glitch filter plus falling-edge pulse for one line. Instantiate it for clk; the data line uses only the synchroniser part. The receiver can reuse it.

Test Plan:
- Send 0xED; device model clocks at 12.5 kHz, acks. Required:
  - clk_oe held low 3000 cycles, then start 0.
  - Device samples bits 1,0,1,1,0,1,1,1, then parity 1, then stop 1.
  - One done pulse; tx_ready=1 afterwards.
- Parity: send 0x00, 0xFF, 0x01. Device captures parity 1, 1, 0 respectively; all complete with done.
- Device never clocks after release. Required: err pulse exactly 375000 cycles after RELEASE; both oe=0; no done.
- Device leaves data high at the 11th falling edge (NACK). Required: err pulse on that edge; lines released.
- Reset asserted during bit 4 of SHIFT. Required: next cycle both oe=0, tx_ready=1, no done/err. A new 0xF4 request then completes normally.
- 50 ns low glitches injected on ps2_clk during SHIFT. Required: no extra bit advance; byte received intact. A tx_valid held high during the transfer is not re-accepted until tx_ready=1.
